// File: rtl/mpsoc_wb_pkg.sv
// Shared Wishbone B3 encodings and the burst-master FSM state type.
package mpsoc_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_BURST   = 2'b01,
    ST_BACKOFF = 2'b10
  } wb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  function automatic logic [2:0] cti_for(input logic last_beat);
    return last_beat ? CTI_EOB : CTI_INCR;
  endfunction

endpackage

// File: rtl/mpsoc_wb_burst_master.sv
// Wishbone B3 incrementing-burst master: one command of 1..16 beats at a time,
// with write-data wait states, err abort and bounded rty backoff.
module mpsoc_wb_burst_master
  import mpsoc_wb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int RETRY_MAX = 4
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,

  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [AW-1:0] cmd_adr_i,
  input  logic [3:0]    cmd_len_i,

  input  logic          wdat_valid_i,
  output logic          wdat_ready_o,
  input  logic [DW-1:0] wdat_i,

  output logic          rdat_valid_o,
  output logic [DW-1:0] rdat_o,

  output logic          done_o,
  output logic          err_o,

  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,

  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);

  localparam int RW = $clog2(RETRY_MAX + 2);

  wb_state_e     state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic          we_q, we_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [2:0]    cti_q, cti_d;
  logic          ready_q, ready_d;
  logic [DW-1:0] rdat_q, rdat_d;
  logic          rdat_valid_q, rdat_valid_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          ack_hit_s;
  logic          rty_hit_s;
  logic          abort_s;

  assign wb_cyc_o     = (state_q == ST_BURST);
  assign wb_stb_o     = wb_cyc_o && (!we_q || wdat_valid_i);
  assign wb_adr_o     = adr_q;
  assign wb_we_o      = we_q;
  assign wb_cti_o     = cti_q;
  assign wb_dat_o     = wdat_i;
  assign wb_sel_o     = 4'hF;
  assign wb_bte_o     = BTE_LINEAR;
  assign cmd_ready_o  = ready_q;
  assign rdat_o       = rdat_q;
  assign rdat_valid_o = rdat_valid_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

  // err outranks ack, and ack outranks rty; an exhausted retry budget turns rty into err
  assign ack_hit_s    = wb_stb_o && wb_ack_i && !wb_err_i;
  assign rty_hit_s    = wb_stb_o && wb_rty_i && !wb_err_i && !wb_ack_i;
  assign abort_s      = wb_stb_o && (wb_err_i || (rty_hit_s && (retry_q >= RW'(RETRY_MAX))));
  assign wdat_ready_o = ack_hit_s && we_q;

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    rdat_d       = rdat_q;
    rdat_valid_d = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && ready_q) begin
          state_d = ST_BURST;
          adr_d   = {cmd_adr_i[AW-1:2], 2'b00};
          we_d    = cmd_we_i;
          cnt_d   = cmd_len_i;
          retry_d = {RW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (abort_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (ack_hit_s) begin
          adr_d = adr_q + AW'(3'd4);
          if (!we_q) begin
            rdat_d       = wb_dat_i;
            rdat_valid_d = 1'b1;
          end else begin
            rdat_valid_d = 1'b0;
          end
          if (cnt_q == 4'd0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end else if (rty_hit_s) begin
          state_d = ST_BACKOFF;
          retry_d = retry_q + RW'(1'b1);
        end else begin
          state_d = ST_BURST;
        end
      end
      ST_BACKOFF: begin
        state_d = ST_BURST;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    cti_d   = (state_d == ST_BURST) ? cti_for(cnt_d == 4'd0) : CTI_CLASSIC;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      adr_q        <= {AW{1'b0}};
      we_q         <= 1'b0;
      cnt_q        <= 4'd0;
      retry_q      <= {RW{1'b0}};
      cti_q        <= CTI_CLASSIC;
      ready_q      <= 1'b0;
      rdat_q       <= {DW{1'b0}};
      rdat_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      cti_q        <= cti_d;
      ready_q      <= ready_d;
      rdat_q       <= rdat_d;
      rdat_valid_q <= rdat_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: doc/mpsoc_wb_burst_master.md
MPSOC_WB_BURST_MASTER -- requirements
Module: mpsoc_wb_burst_master

Interface
REQ-001 SHALL have parameter AW, default 32, Wishbone address width.
REQ-002 SHALL have parameter DW, default 32, Wishbone data width.
REQ-003 SHALL have parameter RETRY_MAX, default 4, the number of rty responses tolerated per command before the command aborts.
REQ-004 SHALL have port wb_clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port wb_rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have command ports, all inputs except cmd_ready_o:
- cmd_valid_i, in, 1
- cmd_ready_o, out, 1
- cmd_we_i, in, 1: 1 = write
- cmd_adr_i, in, AW: byte address; bits [1:0] ignored
- cmd_len_i, in, 4: beats-1, giving 1..16 beats
REQ-007 SHALL have write-data ports: wdat_valid_i in 1; wdat_ready_o out 1; wdat_i in DW.
REQ-008 SHALL have read-data ports: rdat_valid_o out 1; rdat_o out DW. There is no backpressure on read data.
REQ-009 SHALL have status outputs done_o (out, 1) and err_o (out, 1), both single-cycle pulses.
REQ-010 SHALL have Wishbone B3 master outputs: wb_adr_o AW; wb_dat_o DW; wb_sel_o 4; wb_we_o 1; wb_cyc_o 1; wb_stb_o 1; wb_cti_o 3; wb_bte_o 2.
REQ-011 SHALL have Wishbone B3 master inputs: wb_dat_i DW; wb_ack_i 1; wb_err_i 1; wb_rty_i 1.

Function
REQ-012 SHALL implement FSM states IDLE, BURST and BACKOFF.
REQ-013 SHALL drive cmd_ready_o=1 only in IDLE. A command is accepted when cmd_valid_i && cmd_ready_o; address, we and beat count are latched and the FSM enters BURST.
REQ-014 SHALL assert wb_cyc_o the cycle after command acceptance and hold it throughout BURST; wb_adr_o, wb_we_o and wb_cti_o are registered.
REQ-015 SHALL drive wb_stb_o = cyc && (read || wdat_valid_i). For writes, a write-data gap deasserts stb (wait state) while cyc stays high.
REQ-016 SHALL drive wb_dat_o=wdat_i, wdat_ready_o = wb_ack_i && wb_stb_o && wb_we_o, wb_sel_o=4'hF and wb_bte_o=2'b00 (linear).
REQ-017 SHALL drive wb_cti_o=3'b010 for every beat except the last remaining beat, which uses 3'b111; a 1-beat command uses 3'b111 only.
REQ-018 SHALL, on each ack with no err in the same cycle: add 4 to the address (wrapping modulo 2^AW) and decrement the remaining-beat count.
REQ-019 SHALL, on each read ack, register wb_dat_i to rdat_o with rdat_valid_o=1 for exactly one cycle, one cycle after the ack.
REQ-020 SHALL, on the ack of the last beat, drop cyc/stb the next cycle, pulse done_o in that same cycle and return to IDLE.
REQ-021 SHALL give wb_err_i priority over wb_ack_i when both are asserted in the same cycle: the beat is not counted, no write data is consumed, and the burst aborts. Cyc drops the next cycle, done_o and err_o pulse together, and the FSM returns to IDLE.
REQ-022 SHALL handle wb_rty_i (without err) as follows: drop cyc/stb for exactly one cycle (BACKOFF), then resume BURST at the current address with the remaining beats. The retry counter increments per rty.
REQ-023 SHALL, on the rty that would exceed RETRY_MAX, treat the response as err per REQ-021. The retry counter clears on command acceptance.
REQ-024 SHALL deassert cyc/stb in the cycle after any of ack, err or rty terminates the final beat; the master never holds stb across a terminating err or rty.

Reset
REQ-025 SHALL, while wb_rst_i=1 (asynchronously), set the FSM to IDLE and force: wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_cti_o=0, cmd_ready_o=0, rdat_valid_o=0, done_o=0, err_o=0, wdat_ready_o=0.
REQ-026 SHALL abandon an in-flight burst on reset with no done_o or err_o pulse; cmd_ready_o=1 from the first clock edge after wb_rst_i deasserts.

Structure
REQ-027 SHALL take the CTI encodings (CLASSIC 000, INCR 010, EOB 111), the BTE encoding LINEAR 00 and the FSM state type from the shared package mpsoc_wb_pkg.
REQ-028 SHALL be a single module with no sub-modules.

Verification
REQ-029 SHALL cover a 4-beat read: read at 0x100, len=3, slave acks every cycle -> adr 0x100/104/108/10C; cti 010,010,010,111; four rdat pulses; done_o one cycle after the 4th ack.
REQ-030 SHALL cover a write with a gap: 3-beat write at 0x200, wdat_valid_i low for 2 cycles after beat 1 -> stb low for those 2 cycles, cyc stays high, exactly 3 wdat_ready_o pulses, done_o.
REQ-031 SHALL cover a mid-burst error: 4-beat read with err on beat 2 -> 1 rdat pulse; cyc low the next cycle; done_o and err_o pulse together; cmd_ready_o=1.
REQ-032 SHALL cover retries: rty on beat 1 twice, then acks -> cyc low one cycle each time, restart at 0x100, all beats complete, err_o=0. With RETRY_MAX=4 and 5 consecutive rty -> err_o pulse.
REQ-033 SHALL cover reset mid-burst: wb_rst_i asserted during beat 2 -> cyc/stb low immediately, no done_o; a new 1-beat command afterwards completes with cti=111.
REQ-034 SHALL cover the simultaneous case: ack and err in the same cycle -> beat not counted, err_o=1, address not advanced.
